// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the fetch sequencer's control inputs and PC-register outputs
interface fetch_sequencer_if;
    logic [31:0] pc;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        flush_fd;
    logic        fetch_exc;
    logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_cnt;
`endif
    modport master (
        output pc, stall, br_valid, br_target, exc_req, eret_req, epc,
        input  pc_next, pc_we, flush_fd, fetch_exc, state
`ifdef FETCH_PERF_CNT_EN
        , input stall_cycles, redirect_cnt
`endif
    );
    modport slave (
        input  pc, stall, br_valid, br_target, exc_req, eret_req, epc,
        output pc_next, pc_we, flush_fd, fetch_exc, state
`ifdef FETCH_PERF_CNT_EN
        , output stall_cycles, redirect_cnt
`endif
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC selection and one-entry redirect buffer; FETCH_PERF_CNT_EN adds stall/redirect counters
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_4FFC
) (
    input  logic             clk,
    input  logic             reset,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_t;
    state_t      r_state, w_next_state;
    logic [31:0] r_pend_pc, w_next_pend, w_seq;
    assign w_seq = bus.pc + 32'd4;
    // State and buffered redirect target
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pend_pc <= w_next_pend;
        end
    end
    // Next state: exc/eret preempt everything, a stalled branch is parked in PEND
    always_comb begin
        w_next_state = r_state;
        w_next_pend  = r_pend_pc;
        if (bus.exc_req || bus.eret_req) begin
            w_next_state = FLUSH;
            w_next_pend  = '0;
        end else begin
            case (r_state)
                RUN: if (bus.br_valid && bus.stall) begin
                    w_next_state = PEND;
                    w_next_pend  = bus.br_target;
                end
                PEND: if (!bus.stall) w_next_state = RUN;
                default: w_next_state = RUN;
            endcase
        end
    end
    // Outputs: PC source and write enable in priority order
    always_comb begin
        bus.pc_next  = w_seq;
        bus.pc_we    = 1'b1;
        bus.flush_fd = 1'b0;
        if (reset) begin
            bus.pc_next  = RESET_PC;
            bus.flush_fd = 1'b1;
        end else if (bus.exc_req) begin
            bus.pc_next  = HANDLER_PC;
            bus.flush_fd = 1'b1;
        end else if (bus.eret_req) begin
            bus.pc_next  = bus.epc;
            bus.flush_fd = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    bus.pc_we = !bus.stall;
                    if (bus.br_valid && !bus.stall) bus.pc_next = bus.br_target;
                end
                PEND: begin
                    bus.pc_next = r_pend_pc;
                    bus.pc_we   = !bus.stall;
                end
                default: ;
            endcase
        end
    end
    assign bus.state     = r_state;
    assign bus.fetch_exc = (bus.pc < IM_LO) || (bus.pc > IM_HI) || (bus.pc[1:0] != 2'b00);
`ifdef FETCH_PERF_CNT_EN
    logic        w_redirect;
    logic [31:0] r_stall_cycles, r_redirect_cnt;
    assign w_redirect = bus.exc_req || bus.eret_req ||
                        (r_state == RUN && bus.br_valid && !bus.stall) ||
                        (r_state == PEND && !bus.stall);
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (!bus.pc_we && r_stall_cycles != 32'hFFFF_FFFF) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_redirect && r_redirect_cnt != 32'hFFFF_FFFF) r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.redirect_cnt = r_redirect_cnt;
`endif
endmodule
